// File: rtl/ares_stream_pkg.sv
// Shared stream constants, index types and lane-strobe helper for the
// ADC-sample packing/unpacking paths.
package ares_stream_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int LANES       = 8;
  localparam int FRAME_WORDS = 128;
  localparam int LANE_IDX_W  = $clog2(LANES);
  localparam int WORD_IDX_W  = $clog2(FRAME_WORDS);

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;
  typedef logic [WORD_IDX_W-1:0] word_idx_t;

  // Byte strobe for a word whose highest filled lane is last_lane.
  function automatic logic [2*LANES-1:0] lane_strb(input lane_idx_t last_lane);
    logic [2*LANES-1:0] s;
    s = '0;
    for (int k = 0; k < LANES; k++) begin
      if (k <= int'(last_lane)) s[2*k +: 2] = 2'b11;
    end
    return s;
  endfunction

endpackage

// File: rtl/sample_packer.sv
// Packs 16-bit samples into 8-lane 128-bit AXI-Stream words, framing them
// with tlast every FRAME_WORDS words or early on an input tlast (zero-padded).
module sample_packer #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 128,
  parameter int FRAME_WORDS            = ares_stream_pkg::FRAME_WORDS
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_aresetn,
  input  logic                                  s00_axis_tvalid,
  input  logic                                  s00_axis_tlast,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
  output logic                                  s00_axis_tready,
  input  logic                                  m00_axis_tready,
  output logic                                  m00_axis_tvalid,
  output logic                                  m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic [15:0]                           frame_count,
  output logic                                  short_frame
);
  import ares_stream_pkg::*;

  localparam int WORD_W = LANES * SAMPLE_W;
  localparam int WIDX_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  logic [SAMPLE_W-1:0]                 w_sample;
  logic                                w_unused;
  lane_idx_t                           r_lane_idx;
  logic [WIDX_W-1:0]                   r_word_idx;
  logic [WORD_W-1:0]                   r_acc;
  logic [WORD_W-1:0]                   w_acc_next;
  logic                                r_m_tvalid;
  logic                                r_m_tlast;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0]   r_m_tdata;
  logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] r_m_tstrb;
  logic [15:0]                         r_frame_count;
  logic                                r_short;
  logic                                w_lane_last;
  logic                                w_may_complete;
  logic                                w_s_ready;
  logic                                w_in_hs;
  logic                                w_complete;
  logic                                w_word_last;
  logic                                w_frame_end;
  logic                                w_short;

  assign w_sample = s00_axis_tdata[SAMPLE_W-1:0];
  assign w_unused = ^{s00_axis_tstrb, s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:SAMPLE_W]};

  // Only a sample that would complete a word can be stalled: it needs the
  // output register free (or freeing this cycle). Independent of tvalid.
  assign w_lane_last    = (r_lane_idx == lane_idx_t'(LANES-1));
  assign w_may_complete = w_lane_last || s00_axis_tlast;
  assign w_s_ready      = !w_may_complete || !r_m_tvalid || m00_axis_tready;
  assign w_in_hs        = s00_axis_tvalid && w_s_ready;
  assign w_complete     = w_in_hs && w_may_complete;

  assign w_word_last = (r_word_idx == WIDX_W'(FRAME_WORDS-1));
  assign w_frame_end = w_complete && (w_word_last || s00_axis_tlast);
  assign w_short     = w_complete && s00_axis_tlast && (!w_word_last || !w_lane_last);

  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[r_lane_idx*SAMPLE_W +: SAMPLE_W] = w_sample;
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_acc         <= '0;
      r_lane_idx    <= '0;
      r_word_idx    <= '0;
      r_m_tvalid    <= 1'b0;
      r_m_tlast     <= 1'b0;
      r_m_tdata     <= '0;
      r_m_tstrb     <= '0;
      r_frame_count <= '0;
      r_short       <= 1'b0;
    end else begin
      r_short <= w_short;

      // Accumulator lanes above the last written one stay zero, so a
      // completed word needs no explicit padding.
      if (w_complete) begin
        r_acc      <= '0;
        r_lane_idx <= '0;
      end else if (w_in_hs) begin
        r_acc      <= w_acc_next;
        r_lane_idx <= r_lane_idx + 1'b1;
      end

      if (w_complete) begin
        r_m_tvalid <= 1'b1;
        r_m_tdata  <= C_M00_AXIS_TDATA_WIDTH'(w_acc_next);
        r_m_tstrb  <= (C_M00_AXIS_TDATA_WIDTH/8)'(lane_strb(r_lane_idx));
        r_m_tlast  <= w_frame_end;
        r_word_idx <= w_frame_end ? '0 : r_word_idx + 1'b1;
      end else if (r_m_tvalid && m00_axis_tready) begin
        r_m_tvalid <= 1'b0;
      end

      if (w_frame_end) r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign s00_axis_tready = w_s_ready;
  assign m00_axis_tvalid = r_m_tvalid;
  assign m00_axis_tlast  = r_m_tlast;
  assign m00_axis_tdata  = r_m_tdata;
  assign m00_axis_tstrb  = r_m_tstrb;
  assign frame_count     = r_frame_count;
  assign short_frame     = r_short;

endmodule

// File: tb/tb_sample_packer.sv
// Directed bench for sample_packer: full, backpressured, short, exact-boundary,
// reset-mid-frame and single-word-frame cases against hand-built word lists.
module tb_sample_packer;

  logic         clk;
  logic         rst_n;
  logic         s_tvalid, s_tlast, s_tready;
  logic [31:0]  s_tdata;
  logic [3:0]   s_tstrb;
  logic         m_tready, m_tvalid, m_tlast;
  logic [127:0] m_tdata;
  logic [15:0]  m_tstrb;
  logic [15:0]  frame_count;
  logic         short_frame;

  logic         s1_tvalid, s1_tlast, s1_tready;
  logic [31:0]  s1_tdata;
  logic         m1_tvalid, m1_tlast;
  logic [127:0] m1_tdata;
  logic [15:0]  m1_tstrb;
  logic [15:0]  fc1;
  logic         short1;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] got_d[$], exp_d[$];
  logic [15:0]  got_s[$], exp_s[$];
  logic         got_l[$], exp_l[$];

  bit  mon_en = 0;
  bit  bp_en  = 0;
  int  lane   = 0;
  int  n_short = 0;
  int  n1_last = 0, n1_short = 0;
  logic [15:0] last1_strb = '0;

  sample_packer u_dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_tvalid  (s_tvalid),
    .s00_axis_tlast   (s_tlast),
    .s00_axis_tdata   (s_tdata),
    .s00_axis_tstrb   (s_tstrb),
    .s00_axis_tready  (s_tready),
    .m00_axis_tready  (m_tready),
    .m00_axis_tvalid  (m_tvalid),
    .m00_axis_tlast   (m_tlast),
    .m00_axis_tdata   (m_tdata),
    .m00_axis_tstrb   (m_tstrb),
    .frame_count      (frame_count),
    .short_frame      (short_frame)
  );

  sample_packer #(.FRAME_WORDS(1)) u_dut1 (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_tvalid  (s1_tvalid),
    .s00_axis_tlast   (s1_tlast),
    .s00_axis_tdata   (s1_tdata),
    .s00_axis_tstrb   (4'hF),
    .s00_axis_tready  (s1_tready),
    .m00_axis_tready  (1'b1),
    .m00_axis_tvalid  (m1_tvalid),
    .m00_axis_tlast   (m1_tlast),
    .m00_axis_tdata   (m1_tdata),
    .m00_axis_tstrb   (m1_tstrb),
    .frame_count      (fc1),
    .short_frame      (short1)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Downstream ready: always 1, or high one cycle in three when throttled.
  initial begin
    int cyc = 0;
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        cyc++;
        m_tready = (cyc % 3 == 0);
      end else begin
        m_tready = 1'b1;
      end
    end
  end

  // Monitor on the falling edge: collects accepted words, checks hold-stable
  // during stalls and that input stalls only happen on a word-completing beat.
  initial begin
    bit           prev_stall = 0;
    logic [127:0] pd;
    logic [15:0]  ps;
    logic         pl;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", m_tvalid, 1'b1);
          check("hold_data", m_tdata, pd);
          check("hold_strb", m_tstrb, ps);
          check("hold_last", m_tlast, pl);
        end
        prev_stall = m_tvalid && !m_tready;
        pd = m_tdata; ps = m_tstrb; pl = m_tlast;
        if (m_tvalid && m_tready) begin
          got_d.push_back(m_tdata);
          got_s.push_back(m_tstrb);
          got_l.push_back(m_tlast);
        end
        if (short_frame) n_short++;
        if (s_tvalid && !s_tready)
          check("sready_low_only_on_completion", (lane == 7) || s_tlast, 1'b1);
      end
      if (m1_tvalid) begin
        last1_strb = m1_tstrb;
        if (m1_tlast) n1_last++;
      end
      if (short1) n1_short++;
    end
  end

  task automatic send(input int n, input int base, input bit tl);
    for (int i = 0; i < n; i++) begin
      bit accepted = 0;
      int guard = 0;
      s_tvalid = 1'b1;
      s_tdata  = {16'hDEAD, 16'(base + i)};
      s_tlast  = tl && (i == n - 1);
      while (!accepted && guard < 1000) begin
        @(negedge clk);
        if (s_tready) begin
          @(posedge clk);
          #1;
          accepted = 1;
        end else begin
          guard++;
        end
      end
      if (!accepted) begin
        check("input_accept_timeout", 1'b0, 1'b1);
        break;
      end
      lane = (lane == 7 || s_tlast) ? 0 : lane + 1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic add_frame(input int n, input int base, input bit tl);
    int widx = 0;
    for (int w = 0; w * 8 < n; w++) begin
      int cnt;
      logic [127:0] d;
      logic l;
      cnt = (n - 8 * w >= 8) ? 8 : n - 8 * w;
      d = '0;
      for (int k = 0; k < cnt; k++) d[16*k +: 16] = 16'(base + 8 * w + k);
      l = (widx == 127) || (tl && (8 * w + cnt == n));
      exp_d.push_back(d);
      exp_s.push_back(16'((32'd1 << (2 * cnt)) - 1));
      exp_l.push_back(l);
      widx = l ? 0 : widx + 1;
    end
  endtask

  task automatic drain();
    int guard = 0;
    while ((got_d.size() < exp_d.size() || m_tvalid) && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 4000) check("drain_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic compare(input string tag);
    int n;
    check({tag, "_word_count"}, got_d.size(), exp_d.size());
    n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data[%0d]", tag, i), got_d[i], exp_d[i]);
      check($sformatf("%s_strb[%0d]", tag, i), got_s[i], exp_s[i]);
      check($sformatf("%s_last[%0d]", tag, i), got_l[i], exp_l[i]);
    end
  endtask

  task automatic clear_q();
    got_d.delete(); got_s.delete(); got_l.delete();
    exp_d.delete(); exp_s.delete(); exp_l.delete();
    n_short = 0;
  endtask

  initial begin
    rst_n = 0;
    s_tvalid = 0; s_tlast = 0; s_tdata = '0; s_tstrb = 4'hF;
    s1_tvalid = 0; s1_tlast = 0; s1_tdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", m_tvalid, 1'b0);
    check("rst_tlast", m_tlast, 1'b0);
    check("rst_tdata", m_tdata, 128'h0);
    check("rst_tstrb", m_tstrb, 16'h0);
    check("rst_frame_count", frame_count, 16'h0);
    check("rst_short", short_frame, 1'b0);
    rst_n = 1;
    mon_en = 1;
    @(posedge clk);
    #1;

    // Full frame, no backpressure.
    add_frame(1024, 0, 0);
    send(1024, 0, 0);
    drain();
    compare("full");
    if (got_d.size() > 0)
      check("full_word0", got_d[0], 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    check("full_frame_count", frame_count, 16'd1);
    check("full_short", n_short, 0);
    clear_q();

    // Same stream under 1-in-3 downstream ready.
    bp_en = 1;
    add_frame(1024, 16'h1000, 0);
    send(1024, 16'h1000, 0);
    drain();
    bp_en = 0;
    compare("bp");
    check("bp_frame_count", frame_count, 16'd2);
    check("bp_short", n_short, 0);
    clear_q();

    // Short frame: 11 samples, tlast on the last.
    add_frame(11, 16'h2000, 1);
    send(11, 16'h2000, 1);
    drain();
    compare("short");
    if (got_d.size() > 1) begin
      check("short_word1_data", got_d[1], 128'h0000_0000_0000_0000_0000_200A_2009_2008);
      check("short_word1_strb", got_s[1], 16'h003F);
      check("short_word1_last", got_l[1], 1'b1);
    end
    check("short_frame_count", frame_count, 16'd3);
    check("short_pulses", n_short, 1);
    clear_q();

    // Frame after a short one starts aligned.
    add_frame(1024, 16'h3000, 0);
    send(1024, 16'h3000, 0);
    drain();
    compare("after_short");
    check("after_short_frame_count", frame_count, 16'd4);
    clear_q();

    // tlast exactly on the last sample of a full frame.
    add_frame(1024, 16'h4000, 1);
    send(1024, 16'h4000, 1);
    drain();
    compare("exact");
    check("exact_frame_count", frame_count, 16'd5);
    check("exact_short", n_short, 0);
    clear_q();

    // Reset in the middle of a frame, with a word still held downstream.
    bp_en = 1;
    send(300, 16'h5000, 0);
    mon_en = 0;
    #2;
    rst_n = 0;
    #1;
    check("midrst_tvalid", m_tvalid, 1'b0);
    check("midrst_tdata", m_tdata, 128'h0);
    check("midrst_tstrb", m_tstrb, 16'h0);
    check("midrst_tlast", m_tlast, 1'b0);
    check("midrst_frame_count", frame_count, 16'h0);
    bp_en = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    lane = 0;
    clear_q();
    check("midrst_sready", s_tready, 1'b1);
    mon_en = 1;
    add_frame(1024, 16'h6000, 0);
    send(1024, 16'h6000, 0);
    drain();
    compare("post_rst");
    check("post_rst_frame_count", frame_count, 16'd1);
    check("post_rst_short", n_short, 0);
    clear_q();

    // One-word frames: every word carries tlast and bumps frame_count.
    n1_last = 0; n1_short = 0;
    for (int i = 0; i < 16; i++) begin
      s1_tvalid = 1; s1_tdata = 32'(i); s1_tlast = 0;
      @(posedge clk);
      #1;
    end
    s1_tvalid = 0;
    repeat (3) @(posedge clk);
    #1;
    check("fw1_frame_count", fc1, 16'd2);
    check("fw1_tlast_words", n1_last, 2);
    check("fw1_no_short", n1_short, 0);
    for (int i = 0; i < 3; i++) begin
      s1_tvalid = 1; s1_tdata = 32'(i); s1_tlast = (i == 2);
      @(posedge clk);
      #1;
    end
    s1_tvalid = 0; s1_tlast = 0;
    repeat (3) @(posedge clk);
    #1;
    check("fw1_partial_frame_count", fc1, 16'd3);
    check("fw1_partial_short", n1_short, 1);
    check("fw1_partial_strb", last1_strb, 16'h003F);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
